mem_fill_arbiter: RTL

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_picker.sv | 28 ++
 rtl/mem_fill_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory fill arbiter.
package mem_arb_pkg;
  localparam int WORD_BYTES          = 2;
  localparam int DEF_NUM_REQ         = 2;
  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_BLOCK_WORDS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;
endpackage

// File: rtl/arb_picker.sv
// One-hot winner select: search starts at ptr and wraps, first valid requester wins.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  // Walk offsets from farthest to nearest so the nearest valid requester overwrites.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates cache block fills / write-throughs onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             fill_valid,
  output logic [DATA_W-1:0]                fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0]   fill_idx,
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic                             mem_enable,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_data_valid
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  state_t              state;
  logic [IDX_W-1:0]    iss_cnt;
  logic [IDX_W-1:0]    ret_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_REQ-1:0]  pick;
  logic [PTR_W-1:0]    ptr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wr;
  logic                in_fill;
  logic                last_ret;
  logic [ADDR_W-1:0]   base;

  arb_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end
  assign sel_wr = |(pick & req_wr);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_nxt;

  // Pointer holds the index one above the last owner, i.e. where the next search starts.
  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (state == IDLE && |req_valid) ptr <= ptr_nxt;
  end
`else
  assign ptr = '0;
`endif

  assign in_fill    = (state == ISSUE) || (state == DRAIN);
  assign fill_valid = in_fill && mem_data_valid;
  assign last_ret   = fill_valid && (ret_cnt == LAST_IDX);
  assign fill_data  = fill_valid ? mem_rdata : '0;
  assign fill_idx   = ret_cnt;
  assign done       = (last_ret || state == WRITE) ? grant : '0;
  assign busy       = (state != IDLE);
  assign mem_enable = (state == ISSUE) || (state == WRITE);
  assign mem_wr     = (state == WRITE);
  assign base       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_addr   = (state == ISSUE) ? (base | {{(ADDR_W-OFF_W){1'b0}}, iss_cnt, 1'b0}) :
                      (state == WRITE) ? addr_q : '0;
  assign mem_wdata  = (state == WRITE) ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          iss_cnt <= '0;
          ret_cnt <= '0;
          if (|req_valid) begin
            grant   <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            state   <= sel_wr ? WRITE : ISSUE;
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == LAST_IDX) state <= DRAIN;
          end
          if (fill_valid) ret_cnt <= ret_cnt + 1'b1;
          // A short memory latency can finish the block before issue wraps up.
          if (last_ret) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        WRITE: begin
          state <= IDLE;
          grant <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
